// File: rtl/ac_pkg.sv
// ---------------------------------------------------------------------------
// ac_pkg -- shared definitions for the accumulator CPU.
//
// Holds the opcode map, the control FSM state encoding, the flag bit
// positions and small decode helpers. The control unit, branch logic and
// ALU all import this package, so the encodings here are the single source
// of truth for the whole datapath.
// ---------------------------------------------------------------------------
package ac_pkg;

    localparam int OP_W   = 3;
    localparam int FLAG_W = 2;
    localparam int INSTR_W = 8;

    // Bit positions inside the flag vector.
    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;

    typedef enum logic [OP_W-1:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_LDA = 3'b010,
        OP_STA = 3'b011,
        OP_JMP = 3'b100,
        OP_JZ  = 3'b101,
        OP_JC  = 3'b110,
        OP_HLT = 3'b111
    } opcode_e;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_MEM_RD = 3'd2,
        ST_MEM_WR = 3'd3,
        ST_JUMP   = 3'd4,
        ST_HALT   = 3'd5
    } state_e;

    // State entered after DECODE for a given opcode.
    function automatic state_e decode_target(input opcode_e op);
        state_e target;
        case (op)
            OP_ADD, OP_SUB, OP_LDA: target = ST_MEM_RD;
            OP_STA:                 target = ST_MEM_WR;
            OP_JMP, OP_JZ, OP_JC:   target = ST_JUMP;
            default:                target = ST_HALT;
        endcase
        return target;
    endfunction

    // ADD/SUB produce both Z and C; LDA produces only Z.
    function automatic logic updates_carry(input opcode_e op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

    function automatic logic updates_zero(input opcode_e op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_LDA);
    endfunction

endpackage

// File: rtl/ctrl_unit_if.sv
// ---------------------------------------------------------------------------
// ctrl_unit_if -- bundle between the control unit and the rest of the CPU.
//
// Inputs to the control unit (driven by memory / IR / ALU):
//   instr_i[7:0]  instruction word, opcode in [7:5]
//   mem_ready_i   memory completes the current access this cycle
//   alu_zero_i    ALU result zero
//   alu_carry_i   ALU carry/borrow out
// Outputs of the control unit:
//   op_o[2:0]     registered opcode of the current instruction
//   flags_o[1:0]  registered flags, [0]=Z, [1]=C
//   ctrl_jmp_o    branch-evaluate strobe
//   mem_rd_o, mem_we_o, addr_sel_o
//   ir_load_o, pc_inc_o, acc_load_o
//   halt_o
// The master modport is the control unit; the slave modport is the datapath.
// ---------------------------------------------------------------------------
interface ctrl_unit_if;

    logic [7:0] instr_i;
    logic       mem_ready_i;
    logic       alu_zero_i;
    logic       alu_carry_i;

    logic [2:0] op_o;
    logic [1:0] flags_o;
    logic       ctrl_jmp_o;
    logic       mem_rd_o;
    logic       mem_we_o;
    logic       addr_sel_o;
    logic       ir_load_o;
    logic       pc_inc_o;
    logic       acc_load_o;
    logic       halt_o;

    modport master (
        input  instr_i, mem_ready_i, alu_zero_i, alu_carry_i,
        output op_o, flags_o, ctrl_jmp_o, mem_rd_o, mem_we_o, addr_sel_o,
               ir_load_o, pc_inc_o, acc_load_o, halt_o
    );

    modport slave (
        output instr_i, mem_ready_i, alu_zero_i, alu_carry_i,
        input  op_o, flags_o, ctrl_jmp_o, mem_rd_o, mem_we_o, addr_sel_o,
               ir_load_o, pc_inc_o, acc_load_o, halt_o
    );

endinterface

// File: rtl/ctrl_unit_flag_reg.sv
// ---------------------------------------------------------------------------
// flag_reg -- two-bit processor status register.
//
// Ports:
//   clk_i   system clock
//   rst_ni  asynchronous active-low reset, clears both flags
//   z_load  load enable for Z (bit 0)
//   c_load  load enable for C (bit 1)
//   z_in    new Z value
//   c_in    new C value
//   flags   registered flags, [0]=Z, [1]=C
// Each bit has its own enable so an instruction can update Z while the
// previous C is retained.
// ---------------------------------------------------------------------------
module flag_reg
    import ac_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              z_load,
    input  logic              c_load,
    input  logic              z_in,
    input  logic              c_in,
    output logic [FLAG_W-1:0] flags
);

    logic [FLAG_W-1:0] load_vec;
    logic [FLAG_W-1:0] data_vec;
    logic [FLAG_W-1:0] flags_reg;

    always_comb begin
        load_vec         = '0;
        data_vec         = '0;
        load_vec[FLAG_Z] = z_load;
        load_vec[FLAG_C] = c_load;
        data_vec[FLAG_Z] = z_in;
        data_vec[FLAG_C] = c_in;
    end

    generate
        for (genvar gi = 0; gi < FLAG_W; gi++) begin : g_flag_bit
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    flags_reg[gi] <= 1'b0;
                end else if (load_vec[gi]) begin
                    flags_reg[gi] <= data_vec[gi];
                end
            end
        end
    endgenerate

    assign flags = flags_reg;

endmodule

// File: rtl/ctrl_unit.sv
// ---------------------------------------------------------------------------
// ctrl_unit -- multi-cycle control FSM of the accumulator CPU.
//
// Ports:
//   clk_i   system clock, all state changes on the rising edge
//   rst_ni  asynchronous active-low reset
//   bus     ctrl_unit_if.master: instruction, memory handshake and ALU
//           status in; opcode, flags and datapath strobes out
//
// Instruction flow: FETCH -> DECODE -> {MEM_RD | MEM_WR | JUMP | HALT}
// -> FETCH. Each memory wait cycle stretches FETCH/MEM_RD/MEM_WR by one.
// Strobes are decoded from the current state (plus mem_ready where an
// access completes), so they are valid in the same cycle as the state.
// ---------------------------------------------------------------------------
module ctrl_unit
    import ac_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_ni,
    ctrl_unit_if.master  bus
);

    state_e     state_reg;
    state_e     state_next;
    opcode_e    op_reg;
    opcode_e    op_next;
    opcode_e    instr_op;

    // Cleared by reset and set on the first clock edge afterwards. While
    // clear, every strobe is held low: without it the reset state (FETCH)
    // would present mem_rd during reset.
    logic       active_reg;

    logic       mem_rd;
    logic       mem_we;
    logic       addr_sel;
    logic       ir_load;
    logic       pc_inc;
    logic       acc_load;
    logic       ctrl_jmp;
    logic       halt;
    logic       z_load;
    logic       c_load;
    logic [FLAG_W-1:0] flags;

    assign instr_op = opcode_e'(bus.instr_i[7:5]);

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg  <= ST_FETCH;
            op_reg     <= OP_ADD;
            active_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            op_reg     <= op_next;
            active_reg <= 1'b1;
        end
    end

    // ------------------------------------------------ next state / outputs
    always_comb begin
        state_next = state_reg;
        op_next    = op_reg;
        mem_rd     = 1'b0;
        mem_we     = 1'b0;
        addr_sel   = 1'b0;
        ir_load    = 1'b0;
        pc_inc     = 1'b0;
        acc_load   = 1'b0;
        ctrl_jmp   = 1'b0;
        halt       = 1'b0;
        z_load     = 1'b0;
        c_load     = 1'b0;

        if (active_reg) begin
            case (state_reg)
                ST_FETCH: begin
                    mem_rd = 1'b1;
                    if (bus.mem_ready_i) begin
                        ir_load    = 1'b1;
                        pc_inc     = 1'b1;
                        state_next = ST_DECODE;
                    end
                end

                // mem_ready is deliberately not looked at here.
                ST_DECODE: begin
                    op_next    = instr_op;
                    state_next = decode_target(instr_op);
                end

                // Flags are captured only on the completing edge, using the
                // opcode latched in DECODE.
                ST_MEM_RD: begin
                    mem_rd   = 1'b1;
                    addr_sel = 1'b1;
                    if (bus.mem_ready_i) begin
                        acc_load   = 1'b1;
                        z_load     = updates_zero(op_reg);
                        c_load     = updates_carry(op_reg);
                        state_next = ST_FETCH;
                    end
                end

                ST_MEM_WR: begin
                    mem_we   = 1'b1;
                    addr_sel = 1'b1;
                    if (bus.mem_ready_i) begin
                        state_next = ST_FETCH;
                    end
                end

                // One-cycle strobe; the branch logic decides from op_o and
                // flags_o, which both stay stable through this state.
                ST_JUMP: begin
                    ctrl_jmp   = 1'b1;
                    state_next = ST_FETCH;
                end

                ST_HALT: begin
                    halt       = 1'b1;
                    state_next = ST_HALT;
                end

                // Unused encodings recover to a clean fetch.
                default: begin
                    state_next = ST_FETCH;
                end
            endcase
        end
    end

    // ---------------------------------------------------------------- flags
    flag_reg u_flag_reg (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .z_load (z_load),
        .c_load (c_load),
        .z_in   (bus.alu_zero_i),
        .c_in   (bus.alu_carry_i),
        .flags  (flags)
    );

    // -------------------------------------------------------------- outputs
    assign bus.op_o       = op_reg;
    assign bus.flags_o    = flags;
    assign bus.mem_rd_o   = mem_rd;
    assign bus.mem_we_o   = mem_we;
    assign bus.addr_sel_o = addr_sel;
    assign bus.ir_load_o  = ir_load;
    assign bus.pc_inc_o   = pc_inc;
    assign bus.acc_load_o = acc_load;
    assign bus.ctrl_jmp_o = ctrl_jmp;
    assign bus.halt_o     = halt;

endmodule

// File: tb/tb_ctrl_unit.sv
// ---------------------------------------------------------------------------
// tb_ctrl_unit -- directed, cycle-by-cycle check of ctrl_unit.
//
// The stimulus process applies one row per clock cycle (inputs plus the
// hand-derived expected outputs for that cycle) and pushes the expectation
// into a queue. A separate monitor pops one entry at each falling edge and
// compares it with what the DUT is presenting.
// Strobe byte layout: [7]halt [6]jmp [5]acc_load [4]pc_inc [3]ir_load
//                     [2]addr_sel [1]mem_we [0]mem_rd
// ---------------------------------------------------------------------------
module tb_ctrl_unit;

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;

    ctrl_unit_if bus();

    ctrl_unit dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    always #5 clk_i = ~clk_i;

    localparam logic [7:0] S_NONE  = 8'h00;
    localparam logic [7:0] S_FWAIT = 8'h01; // mem_rd
    localparam logic [7:0] S_FDONE = 8'h19; // mem_rd, ir_load, pc_inc
    localparam logic [7:0] S_RWAIT = 8'h05; // mem_rd, addr_sel
    localparam logic [7:0] S_RDONE = 8'h25; // mem_rd, addr_sel, acc_load
    localparam logic [7:0] S_WR    = 8'h06; // mem_we, addr_sel
    localparam logic [7:0] S_JMP   = 8'h40;
    localparam logic [7:0] S_HALT  = 8'h80;

    typedef struct packed {
        logic [7:0] row;
        logic [7:0] strobe;
        logic [2:0] op;
        logic [1:0] flags;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_compared   = 0;
    int   n_mismatched = 0;
    int   row_id       = 0;

    logic [7:0] got_strobe;
    assign got_strobe = {bus.halt_o, bus.ctrl_jmp_o, bus.acc_load_o, bus.pc_inc_o,
                         bus.ir_load_o, bus.addr_sel_o, bus.mem_we_o, bus.mem_rd_o};

    // One cycle of stimulus: apply inputs just after the rising edge, record
    // what the outputs must be before the next edge, then advance.
    task automatic step(input logic rst, input logic [7:0] instr, input logic rdy,
                        input logic z, input logic c, input logic [7:0] strobe,
                        input logic [2:0] op, input logic [1:0] flags);
        exp_t e;
        rst_ni          = rst;
        bus.instr_i     = instr;
        bus.mem_ready_i = rdy;
        bus.alu_zero_i  = z;
        bus.alu_carry_i = c;
        row_id          = row_id + 1;
        e.row    = 8'(row_id);
        e.strobe = strobe;
        e.op     = op;
        e.flags  = flags;
        exp_q.push_back(e);
        @(posedge clk_i);
        #1;
    endtask

    // Monitor: compares whatever the DUT presents against the oldest entry.
    always @(negedge clk_i) begin
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            n_compared = n_compared + 1;
            if ({got_strobe, bus.op_o, bus.flags_o} !== {mon_e.strobe, mon_e.op, mon_e.flags}) begin
                n_mismatched = n_mismatched + 1;
                $display("FAIL row%0d: strobes=%b op=%b flags=%b, required strobes=%b op=%b flags=%b",
                         mon_e.row, got_strobe, bus.op_o, bus.flags_o,
                         mon_e.strobe, mon_e.op, mon_e.flags);
            end else begin
                $display("row%0d: strobes=%b op=%b flags=%b ok",
                         mon_e.row, got_strobe, bus.op_o, bus.flags_o);
            end
        end
    end

    initial begin
        bus.instr_i     = 8'h00;
        bus.mem_ready_i = 1'b0;
        bus.alu_zero_i  = 1'b0;
        bus.alu_carry_i = 1'b0;
        @(posedge clk_i);
        #1;

        // Reset state, then release: outputs stay quiet until the first edge.
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, S_NONE, 3'b000, 2'b00);
        step(1'b0, 8'hFF, 1'b1, 1'b1, 1'b1, S_NONE, 3'b000, 2'b00);
        step(1'b1, 8'h05, 1'b1, 1'b1, 1'b1, S_NONE, 3'b000, 2'b00);

        // ADD, Z=1 C=1, no waits.
        step(1'b1, 8'h05, 1'b1, 1'b1, 1'b1, S_FDONE, 3'b000, 2'b00);
        step(1'b1, 8'h05, 1'b1, 1'b1, 1'b1, S_NONE,  3'b000, 2'b00);
        step(1'b1, 8'h05, 1'b1, 1'b1, 1'b1, S_RDONE, 3'b000, 2'b00);

        // LDA, Z=0 C=0, one wait in MEM_RD: C must be retained.
        step(1'b1, 8'h4A, 1'b1, 1'b0, 1'b0, S_FDONE, 3'b000, 2'b11);
        step(1'b1, 8'h4A, 1'b1, 1'b0, 1'b0, S_NONE,  3'b000, 2'b11);
        step(1'b1, 8'h4A, 1'b0, 1'b0, 1'b0, S_RWAIT, 3'b010, 2'b11);
        step(1'b1, 8'h4A, 1'b1, 1'b0, 1'b0, S_RDONE, 3'b010, 2'b11);

        // SUB with one fetch wait, Z=1 C=0.
        step(1'b1, 8'h21, 1'b0, 1'b1, 1'b0, S_FWAIT, 3'b010, 2'b10);
        step(1'b1, 8'h21, 1'b1, 1'b1, 1'b0, S_FDONE, 3'b010, 2'b10);
        step(1'b1, 8'h21, 1'b1, 1'b1, 1'b0, S_NONE,  3'b010, 2'b10);
        step(1'b1, 8'h21, 1'b1, 1'b1, 1'b0, S_RDONE, 3'b001, 2'b10);

        // STA with four wait cycles: mem_we for five cycles, flags untouched.
        step(1'b1, 8'h63, 1'b1, 1'b0, 1'b0, S_FDONE, 3'b001, 2'b01);
        step(1'b1, 8'h63, 1'b1, 1'b1, 1'b1, S_NONE,  3'b001, 2'b01);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 8'h63, 1'b0, 1'b1, 1'b1, S_WR, 3'b011, 2'b01);
        end
        step(1'b1, 8'h63, 1'b1, 1'b1, 1'b1, S_WR, 3'b011, 2'b01);

        // JZ: one-cycle strobe with op 101, flags from SUB still visible.
        step(1'b1, 8'hA0, 1'b1, 1'b0, 1'b0, S_FDONE, 3'b011, 2'b01);
        step(1'b1, 8'hA0, 1'b1, 1'b0, 1'b0, S_NONE,  3'b011, 2'b01);
        step(1'b1, 8'hA0, 1'b1, 1'b1, 1'b1, S_JMP,   3'b101, 2'b01);

        // JC right after, mem_ready low in JUMP (ignored).
        step(1'b1, 8'hC0, 1'b1, 1'b0, 1'b0, S_FDONE, 3'b101, 2'b01);
        step(1'b1, 8'hC0, 1'b1, 1'b0, 1'b0, S_NONE,  3'b101, 2'b01);
        step(1'b1, 8'hC0, 1'b0, 1'b1, 1'b1, S_JMP,   3'b110, 2'b01);

        // LDA interrupted by reset while waiting in MEM_RD.
        step(1'b1, 8'h4A, 1'b1, 1'b0, 1'b0, S_FDONE, 3'b110, 2'b01);
        step(1'b1, 8'h4A, 1'b1, 1'b0, 1'b0, S_NONE,  3'b110, 2'b01);
        step(1'b1, 8'h4A, 1'b0, 1'b1, 1'b1, S_RWAIT, 3'b010, 2'b01);
        step(1'b0, 8'h4A, 1'b1, 1'b1, 1'b1, S_NONE,  3'b000, 2'b00);

        // HLT: halt held for 20 cycles whatever mem_ready does.
        step(1'b1, 8'hE0, 1'b1, 1'b0, 1'b0, S_NONE,  3'b000, 2'b00);
        step(1'b1, 8'hE0, 1'b1, 1'b0, 1'b0, S_FDONE, 3'b000, 2'b00);
        step(1'b1, 8'hE0, 1'b1, 1'b0, 1'b0, S_NONE,  3'b000, 2'b00);
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 8'hE0, 1'(i % 2), 1'b1, 1'b1, S_HALT, 3'b111, 2'b00);
        end

        // Only reset leaves HALT; fetching resumes afterwards.
        step(1'b0, 8'h05, 1'b1, 1'b0, 1'b0, S_NONE,  3'b000, 2'b00);
        step(1'b1, 8'h05, 1'b0, 1'b0, 1'b0, S_NONE,  3'b000, 2'b00);
        step(1'b1, 8'h05, 1'b0, 1'b0, 1'b0, S_FWAIT, 3'b000, 2'b00);

        // Give the monitor a bounded window to consume everything queued.
        for (int i = 0; i < 4; i++) begin
            if (exp_q.size() != 0) @(posedge clk_i);
        end
        if (exp_q.size() != 0) begin
            n_mismatched = n_mismatched + 1;
            $display("FAIL drain: %0d entries left, required 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
